// File: rtl/addsub_sequencer_if.sv
// addsub_sequencer_if: operation request and result signals of the add/sub sequencer
interface addsub_sequencer_if #(parameter int SLICES = 4);
    localparam int W = 8 * SLICES;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;
    modport master(output start, sub, a, b, input ready, busy, done, result, cout, overflow);
    modport slave(input start, sub, a, b, output ready, busy, done, result, cout, overflow);
endinterface

// File: rtl/addsub_sequencer.sv
// addsub_sequencer: W-bit add/subtract computed one byte per cycle on a single shared 8-bit adder
module eightbit_adder (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       cin,
    output logic [7:0] s,
    output logic       co,
    output logic       c7
);
    assign {co, s} = 9'(x) + 9'(y) + 9'(cin);
    assign c7 = x[7] ^ y[7] ^ s[7];
endmodule

module addsub_sequencer #(parameter int SLICES = 4) (
    input logic clk,
    input logic reset,
    addsub_sequencer_if.slave bus
);
    localparam int W  = 8 * SLICES;
    localparam int IW = $clog2(SLICES);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [IW-1:0] idx;
    logic [W-1:0] a_r, b_r;
    logic carry, co, c7, last;
    logic [7:0] sum;

    eightbit_adder u_add (
        .x(a_r[8*idx +: 8]),
        .y(b_r[8*idx +: 8]),
        .cin(carry),
        .s(sum),
        .co(co),
        .c7(c7)
    );

    assign last = idx == IW'(SLICES - 1);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = (state == IDLE && bus.start) ? RUN :
                  (state == RUN && last)       ? DONE :
                  (state == DONE)              ? IDLE : state;
    end

    always_comb begin
        bus.ready = state == IDLE;
        bus.busy  = state == RUN;
        bus.done  = state == DONE;
    end

    // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx          <= '0;
            carry        <= 1'b0;
            a_r          <= '0;
            b_r          <= '0;
            bus.result   <= '0;
            bus.cout     <= 1'b0;
            bus.overflow <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            a_r   <= bus.a;
            b_r   <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub;
            idx   <= '0;
        end else if (state == RUN) begin
            bus.result[8*idx +: 8] <= sum;
            carry <= co;
            idx   <= last ? '0 : idx + 1'b1;
            if (last) begin
                bus.cout     <= co;
                bus.overflow <= co ^ c7;
            end
        end
    end
endmodule

// File: doc/addsub_sequencer.md
ADDSUB_SEQUENCER -- requirements
Module: addsub_sequencer

Interface
REQ-001 Parameter SLICES, default 4: number of 8-bit slices; operand width W = 8*SLICES; legal range 2..8.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new operation; sampled only when ready=1.
REQ-005 sub  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-006 a  input  W  operand A; sampled with start.
REQ-007 b  input  W  operand B; sampled with start.
REQ-008 ready  output  1  high only in IDLE; start is accepted only then.
REQ-009 busy  output  1  high in RUN.
REQ-010 done  output  1  one-cycle pulse; result, cout and overflow are valid.
REQ-011 result  output  W  sum or difference.
REQ-012 cout  output  1  carry out of bit W-1; for sub, 1 = no borrow (A >= B unsigned).
REQ-013 overflow  output  1  two's-complement signed overflow of the W-bit operation.

Function
REQ-014 The block shall contain exactly one eightbit_adder instance and compute the W-bit result over SLICES cycles, least significant slice first, by time-sharing that instance.
REQ-015 The FSM shall have three states: IDLE, RUN and DONE.
REQ-016 IDLE with start=1 at an edge: the block shall latch a, latch b (or ~b when sub=1), set carry register = sub, set slice index = 0 and move to RUN.
REQ-017 IDLE with start=0: the block shall hold all outputs unchanged.
REQ-018 RUN: the adder shall be driven with operand slice[index] and carry register. At each edge, the sum byte shall be written to result[8*index+7:8*index], the adder cout shall be written to the carry register, and the index shall increment.
REQ-019 RUN at index = SLICES-1: at that edge, cout shall take the adder cout, overflow shall take adder cout XOR carry into bit 7 of that slice, and the state shall move to DONE.
REQ-020 DONE shall last exactly one cycle with done=1, then return to IDLE.
REQ-021 Latency: if start is sampled at edge E0, done shall be high in the cycle following edge E0+SLICES; ready shall return at edge E0+SLICES+1.
REQ-022 result, cout and overflow shall hold their final values from DONE until the next start is accepted; they need not be stable in RUN.
REQ-023 start asserted in RUN or DONE shall be ignored, not queued; a, b and sub changes in RUN shall not affect the operation in progress.
REQ-024 Operand arithmetic shall be modulo 2^W; no saturation.

Reset
REQ-025 reset=1 at an edge shall force IDLE, index=0, carry register=0, result=0, cout=0, overflow=0, done=0, busy=0, ready=1, regardless of state.
REQ-026 reset shall take priority over start in the same cycle; an operation interrupted mid-RUN shall be abandoned without a done pulse.

Verification (SLICES=4)
REQ-027 add 0xFFFFFFFF + 0x00000001 -> done at edge E0+4; result=0x00000000, cout=1, overflow=0.
REQ-028 add 0x7FFFFFFF + 0x00000001 -> result=0x80000000, cout=0, overflow=1.
REQ-029 sub 0x00000005 - 0x00000007 -> result=0xFFFFFFFE, cout=0, overflow=0; sub 0x80000000 - 0x00000001 -> result=0x7FFFFFFF, cout=1, overflow=1.
REQ-030 start pulsed with new operands during RUN -> ignored; the first result completes unchanged; exactly one done pulse; ready=0 throughout.
REQ-031 reset asserted two cycles into RUN -> next cycle IDLE, ready=1, all outputs 0, no done pulse; a fresh 0x12345678 + 0x11111111 then gives 0x23456789, cout=0, overflow=0.
REQ-032 back-to-back: start held high continuously -> operations start every SLICES+2 cycles, each followed by exactly one done pulse.
